// File: rtl/sent_rx_crc_arbiter.sv
// Round-robin arbiter sharing one SENT CRC checker between NUM_CH receive channels.
// Grants a job, pulses the checker enable, and acks the result or a timeout error.
module sent_rx_crc_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                 clk_rx,
    input  logic                 reset_rx,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [3*NUM_CH-1:0]  type_i,
    input  logic [30*NUM_CH-1:0] data_i,
    output logic [NUM_CH-1:0]    ack_o,
    output logic                 crc_ok_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [CH_W-1:0]      grant_ch_o,
    output logic [2:0]           enable_crc_check_o,
    output logic [29:0]          data_check_crc_o,
    input  logic                 valid_data_fast_i,
    input  logic                 valid_data_serial_i,
    input  logic                 valid_data_enhanced_i,
    input  logic                 crc_check_done_i
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q;
    logic [CH_W-1:0]  rr_q;
    logic [NUM_CH-1:0] mask_q;
    logic [2:0]       type_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_CH-1:0] eff_req;
    logic [CH_W-1:0]   pick;
    logic              pick_vld;
    logic [CH_W:0]     sum;
    logic [CH_W-1:0]   idx;
    logic [2:0]        sel_type;
    logic [29:0]       sel_data;
    logic [NUM_CH-1:0] grant_oh;
    logic [CH_W-1:0]   rr_nxt;
    logic              flag_sel;
    logic              timed_out;

    function automatic logic is_onehot(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b010) || (t == 3'b100);
    endfunction

    // The last-acked channel is masked only while the mask is set,
    // which covers exactly the first IDLE cycle after RESP.
    always_comb begin
        eff_req  = req_i & ~mask_q;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_q} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = sum[CH_W-1:0];
            if (!pick_vld && eff_req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_type = '0;
        sel_data = '0;
        grant_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pick == CH_W'(c)) begin
                sel_type = type_i[3*c +: 3];
                sel_data = data_i[30*c +: 30];
            end
            grant_oh[c] = (grant_ch_o == CH_W'(c));
        end
    end

    always_comb begin
        rr_nxt = grant_ch_o + 1'b1;
        if (grant_ch_o == CH_W'(NUM_CH-1)) begin
            rr_nxt = '0;
        end
    end

    assign flag_sel = |(type_q & {valid_data_enhanced_i,
                                  valid_data_serial_i,
                                  valid_data_fast_i});

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT-1));
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            state_q            <= IDLE;
            rr_q               <= '0;
            mask_q             <= '0;
            type_q             <= '0;
            cnt_q              <= '0;
            ack_o              <= '0;
            crc_ok_o           <= 1'b0;
            err_o              <= 1'b0;
            grant_ch_o         <= '0;
            enable_crc_check_o <= '0;
            data_check_crc_o   <= '0;
        end else begin
            ack_o              <= '0;
            crc_ok_o           <= 1'b0;
            err_o              <= 1'b0;
            enable_crc_check_o <= '0;
            unique case (state_q)
                IDLE: begin
                    mask_q <= '0;
                    if (pick_vld) begin
                        grant_ch_o       <= pick;
                        type_q           <= sel_type;
                        data_check_crc_o <= sel_data;
                        state_q          <= ISSUE;
                        // A malformed type never reaches the checker.
                        if (is_onehot(sel_type)) begin
                            enable_crc_check_o <= sel_type;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (is_onehot(type_q)) begin
                        state_q <= WAIT;
                    end else begin
                        state_q <= RESP;
                        ack_o   <= grant_oh;
                        err_o   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (crc_check_done_i) begin
                        state_q  <= RESP;
                        ack_o    <= grant_oh;
                        crc_ok_o <= flag_sel;
                    end else if (timed_out) begin
                        state_q <= RESP;
                        ack_o   <= grant_oh;
                        err_o   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rr_q    <= rr_nxt;
                    mask_q  <= grant_oh;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
